// File: rtl/md5_msg_padder.sv
// rtl/md5_msg_padder.sv - MD5 message padder: byte stream in, padded 512-bit blocks out
// Packs bytes into md5_core_block bit layout and appends 0x80, zero fill and the LE bit length.
module md5_msg_padder #(
  parameter int LEN_W       = 64,
  parameter int BLOCK_BYTES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  input  logic         s_keep,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [511:0] m_block,
  output logic         m_first,
  output logic         m_last
);

  typedef enum logic [1:0] {FILL, EMIT, PAD, PAD2} state_t;

  localparam logic [5:0] LAST_BYTE = 6'(BLOCK_BYTES - 1);
  localparam logic [5:0] LAST_FIT  = 6'(BLOCK_BYTES - 9);

  state_t           state;
  logic [5:0]       p;
  logic [LEN_W-1:0] bit_len;
  logic             first_flag;
  logic             pad_pending;
  logic             pad_pending2;
  logic [8:0]       p_bit;
  logic             beat;

  assign p_bit = {p, 3'b000};
  assign beat  = s_valid && s_ready;

  // The core consumes each byte MSB-first from the low bit of its lane.
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = b[7-j];
    return r;
  endfunction

  function automatic logic [63:0] len_field(input logic [LEN_W-1:0] len);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = rev8(len[8*i +: 8]);
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FILL;
      p            <= '0;
      bit_len      <= '0;
      first_flag   <= 1'b1;
      pad_pending  <= 1'b0;
      pad_pending2 <= 1'b0;
      s_ready      <= 1'b0;
      m_valid      <= 1'b0;
      m_first      <= 1'b0;
      m_last       <= 1'b0;
      m_block      <= '0;
    end else if (clear) begin
      state        <= FILL;
      p            <= '0;
      bit_len      <= '0;
      first_flag   <= 1'b1;
      pad_pending  <= 1'b0;
      pad_pending2 <= 1'b0;
      s_ready      <= 1'b1;
      m_valid      <= 1'b0;
      m_first      <= 1'b0;
      m_last       <= 1'b0;
      m_block      <= '0;
    end else begin
      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (beat) begin
            if (s_keep) begin
              m_block[p_bit +: 8] <= rev8(s_data);
              p                   <= p + 6'd1;
              bit_len             <= bit_len + LEN_W'(8);
            end
            if (s_keep && p == LAST_BYTE) begin
              state       <= EMIT;
              m_valid     <= 1'b1;
              m_first     <= first_flag;
              m_last      <= 1'b0;
              pad_pending <= s_last;
              s_ready     <= 1'b0;
            end else if (s_last) begin
              state   <= PAD;
              s_ready <= 1'b0;
            end
          end
        end
        PAD: begin
          // Bytes above p are already zero: the buffer is cleared on every handshake.
          m_block[p_bit +: 8] <= 8'h01;
          if (p <= LAST_FIT) begin
            m_block[511:448] <= len_field(bit_len);
            m_last           <= 1'b1;
          end else begin
            m_last       <= 1'b0;
            pad_pending2 <= 1'b1;
          end
          state   <= EMIT;
          m_valid <= 1'b1;
          m_first <= first_flag;
        end
        PAD2: begin
          m_block[511:448] <= len_field(bit_len);
          m_last           <= 1'b1;
          pad_pending2     <= 1'b0;
          state            <= EMIT;
          m_valid          <= 1'b1;
          m_first          <= first_flag;
        end
        EMIT: begin
          if (m_ready) begin
            m_valid    <= 1'b0;
            m_block    <= '0;
            p          <= '0;
            first_flag <= 1'b0;
            if (m_last) begin
              bit_len    <= '0;
              first_flag <= 1'b1;
              state      <= FILL;
              s_ready    <= 1'b1;
            end else if (pad_pending) begin
              pad_pending <= 1'b0;
              state       <= PAD;
            end else if (pad_pending2) begin
              state <= PAD2;
            end else begin
              state   <= FILL;
              s_ready <= 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_msg_padder.sv
// tb/tb_md5_msg_padder.sv - directed self-checking bench for md5_msg_padder
module tb_md5_msg_padder;

  logic         clk = 1'b0;
  logic         reset, clear, s_valid, s_ready, s_keep, s_last;
  logic [7:0]   s_data;
  logic         m_valid, m_ready, m_first, m_last;
  logic [511:0] m_block;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   eb [64];
  logic [511:0] got_blk, snap;
  logic         got_first, got_last, stable;

  always #5 clk = ~clk;

  md5_msg_padder dut (
    .clk(clk), .reset(reset), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_block(m_block), .m_first(m_first), .m_last(m_last)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic eb_clear();
    for (int i = 0; i < 64; i++) eb[i] = 8'h00;
  endtask

  function automatic logic [511:0] exp_block();
    logic [511:0] r;
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 8; j++) r[8*k+j] = eb[k][7-j];
    return r;
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
    for (int i = 0; i < 200 && !s_ready; i++) @(negedge clk);
    if (!s_ready) chk("s_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0; s_keep = 1'b0; s_last = 1'b0;
  endtask

  task automatic recv(input string tag);
    for (int i = 0; i < 200 && !m_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, m_valid, 1);
    got_blk = m_block; got_first = m_first; got_last = m_last;
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic check_blk(input string tag, input logic f, input logic l);
    chk({tag, "_block"}, got_blk, exp_block());
    chk({tag, "_first"}, got_first, f);
    chk({tag, "_last"}, got_last, l);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; s_valid = 1'b0; s_keep = 1'b0; s_last = 1'b0;
    s_data = 8'h00; m_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_block", m_block, 0);
    chk("rst_m_first", m_first, 0);
    chk("rst_m_last", m_last, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1);

    // "abc"
    send_beat(8'h61, 1, 0); send_beat(8'h62, 1, 0); send_beat(8'h63, 1, 1);
    chk("abc_pad_cycle_valid", m_valid, 0);
    @(negedge clk);
    chk("abc_latency_valid", m_valid, 1);
    recv("abc");
    eb_clear(); eb[0] = 8'h61; eb[1] = 8'h62; eb[2] = 8'h63; eb[3] = 8'h80; eb[56] = 8'h18;
    check_blk("abc", 1, 1);

    // empty message
    send_beat(8'h00, 0, 1);
    recv("empty");
    eb_clear(); eb[0] = 8'h80;
    check_blk("empty", 1, 1);

    // 55 bytes: padding and length fit in one block
    for (int i = 0; i < 55; i++) send_beat(8'h41, 1, i == 54);
    recv("b55");
    eb_clear();
    for (int i = 0; i < 55; i++) eb[i] = 8'h41;
    eb[55] = 8'h80; eb[56] = 8'hB8; eb[57] = 8'h01;
    check_blk("b55", 1, 1);

    // 56 bytes: length spills into a second block
    for (int i = 0; i < 56; i++) send_beat(8'h41, 1, i == 55);
    recv("b56_1");
    eb_clear();
    for (int i = 0; i < 56; i++) eb[i] = 8'h41;
    eb[56] = 8'h80;
    check_blk("b56_1", 1, 0);
    chk("b56_pad2_cycle_valid", m_valid, 0);
    @(negedge clk);
    chk("b56_pad2_latency_valid", m_valid, 1);
    recv("b56_2");
    eb_clear(); eb[56] = 8'hC0; eb[57] = 8'h01;
    check_blk("b56_2", 0, 1);

    // 64 bytes 00..3F, last on the final byte
    for (int i = 0; i < 64; i++) send_beat(8'(i), 1, i == 63);
    chk("b64_latency_valid", m_valid, 1);
    recv("b64_1");
    eb_clear();
    for (int i = 0; i < 64; i++) eb[i] = 8'(i);
    check_blk("b64_1", 1, 0);
    recv("b64_2");
    eb_clear(); eb[0] = 8'h80; eb[57] = 8'h02;
    check_blk("b64_2", 0, 1);

    // backpressure with a stray beat offered while not ready
    send_beat(8'hDE, 1, 0); send_beat(8'hAD, 1, 1);
    for (int i = 0; i < 20 && !m_valid; i++) @(negedge clk);
    snap = m_block; got_first = m_first; got_last = m_last; stable = 1'b1;
    s_valid = 1'b1; s_data = 8'hFF; s_keep = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_block !== snap || m_first !== got_first || m_last !== got_last ||
          m_valid !== 1'b1 || s_ready !== 1'b0) stable = 1'b0;
    end
    s_valid = 1'b0; s_keep = 1'b0;
    chk("bp_stable", stable, 1);
    recv("bp");
    eb_clear(); eb[0] = 8'hDE; eb[1] = 8'hAD; eb[2] = 8'h80; eb[56] = 8'h10;
    check_blk("bp", 1, 1);

    // clear while a full block is waiting
    for (int i = 0; i < 64; i++) send_beat(8'h77, 1, 0);
    chk("clr_pre_valid", m_valid, 1);
    clear = 1'b1; s_valid = 1'b1; s_data = 8'h99; s_keep = 1'b1;
    @(negedge clk);
    clear = 1'b0; s_valid = 1'b0; s_keep = 1'b0;
    chk("clr_m_valid", m_valid, 0);
    chk("clr_s_ready", s_ready, 1);

    // clear mid-message with a last beat presented in the same cycle
    for (int i = 0; i < 5; i++) send_beat(8'h11, 1, 0);
    clear = 1'b1; s_valid = 1'b1; s_data = 8'h22; s_keep = 1'b1; s_last = 1'b1;
    @(negedge clk);
    clear = 1'b0; s_valid = 1'b0; s_keep = 1'b0; s_last = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("clr2_m_valid", m_valid, 0);
    send_beat(8'h61, 1, 0); send_beat(8'h62, 1, 0); send_beat(8'h63, 1, 1);
    recv("post_clr");
    eb_clear(); eb[0] = 8'h61; eb[1] = 8'h62; eb[2] = 8'h63; eb[3] = 8'h80; eb[56] = 8'h18;
    check_blk("post_clr", 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
